// File: rtl/seg_scan_driver_pkg.sv
// Shared types and active-low segment patterns for the
// multiplexed 4-digit seven-segment scan driver.
package seg_scan_driver_pkg;

  typedef logic [1:0] idx_t;

  // Active-low, bit 0 = a ... bit 6 = g
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] AN_OFF = 4'hF;

  function automatic logic [3:0] an_sel(idx_t i);
    return ~(4'b0001 << i);
  endfunction

endpackage

// File: rtl/seg_scan_driver_seg_decoder.sv
// BCD to active-low seven-segment decode; 10..15 show a dash,
// blank forces all segments off.
module seg_decoder
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end else begin
      unique case (bcd_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed display scanner with per-scan snapshot,
// anode guard band, leading-zero blanking and blinking alarm latch.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV    = 50000,
  parameter int GUARD       = 16,
  parameter int BLINK_SCANS = 64
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] D0,
  input  logic [3:0] D1,
  input  logic [3:0] D2,
  input  logic [3:0] D3,
  input  logic [3:0] DP_MASK,
  input  logic       BLANK_LZ,
  input  logic       TRG,
  input  logic       ACK,
  output logic [3:0] AN,
  output logic [6:0] SEG,
  output logic       DP,
  output logic       ALARM
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_SCANS + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
  localparam logic [BW-1:0] BLK_LAST  = BW'(BLINK_SCANS - 1);

  logic [CW-1:0]   cnt_q, cnt_d;
  idx_t            idx_q, idx_d;
  logic [3:0][3:0] snap_q, snap_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic            boff_q, boff_d;
  logic            trg1_q, trg1_d;
  logic            trg2_q, trg2_d;
  logic            alarm_q, alarm_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  logic       tick;
  logic       scan_end;
  logic       trg_rise;
  logic       guard;
  logic [3:0] lz;
  logic [6:0] dec_seg;

  assign tick     = (cnt_q == CNT_LAST);
  assign scan_end = tick && (idx_q == 2'd3);
  assign trg_rise = trg1_q & ~trg2_q;
  assign guard    = (cnt_q < CNT_GUARD);

  // Blanking ripples down from the leftmost digit; digit 0 always shows
  assign lz[3] = BLANK_LZ && (snap_q[3] == 4'd0);
  assign lz[2] = lz[3] && (snap_q[2] == 4'd0);
  assign lz[1] = lz[2] && (snap_q[1] == 4'd0);
  assign lz[0] = 1'b0;

  seg_decoder u_dec (
    .bcd_i   (snap_q[idx_q]),
    .blank_i (lz[idx_q]),
    .seg_o   (dec_seg)
  );

  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    idx_d   = tick ? idx_q + 2'd1 : idx_q;
    snap_d  = scan_end ? {D3, D2, D1, D0} : snap_q;
    trg1_d  = TRG;
    trg2_d  = trg1_q;

    alarm_d = alarm_q;
    if (ACK)      alarm_d = 1'b0;
    if (trg_rise) alarm_d = 1'b1;

    bcnt_d = bcnt_q;
    boff_d = boff_q;
    if (!alarm_d) begin
      bcnt_d = '0;
      boff_d = 1'b0;
    end else if (alarm_q && scan_end) begin
      if (bcnt_q == BLK_LAST) begin
        bcnt_d = '0;
        boff_d = ~boff_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end

    an_d  = (guard || boff_q) ? AN_OFF : an_sel(idx_q);
    seg_d = dec_seg;
    dp_d  = ~DP_MASK[idx_q];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      bcnt_q  <= '0;
      boff_q  <= 1'b0;
      trg1_q  <= 1'b0;
      trg2_q  <= 1'b0;
      alarm_q <= 1'b0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      bcnt_q  <= bcnt_d;
      boff_q  <= boff_d;
      trg1_q  <= trg1_d;
      trg2_q  <= trg2_d;
      alarm_q <= alarm_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign AN    = an_q;
  assign SEG   = seg_q;
  assign DP    = dp_q;
  assign ALARM = alarm_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=8, GUARD=2,
// BLINK_SCANS=2; k counts sampled cycles since reset release.
module tb_seg_scan_driver;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] D0, D1, D2, D3, DP_MASK;
  logic       BLANK_LZ, TRG, ACK;
  logic [3:0] AN;
  logic [6:0] SEG;
  logic       DP, ALARM;

  int n_chk  = 0;
  int n_fail = 0;
  int k      = 0;

  seg_scan_driver #(
    .SCAN_DIV    (8),
    .GUARD       (2),
    .BLINK_SCANS (2)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .D0       (D0),
    .D1       (D1),
    .D2       (D2),
    .D3       (D3),
    .DP_MASK  (DP_MASK),
    .BLANK_LZ (BLANK_LZ),
    .TRG      (TRG),
    .ACK      (ACK),
    .AN       (AN),
    .SEG      (SEG),
    .DP       (DP),
    .ALARM    (ALARM)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge CLK);
    k++;
  endtask

  task automatic release_rst();
    @(negedge CLK);
    RST = 1'b1;
    k   = -1;
  endtask

  // Ends on the last sample of a scan whose closing capture follows the call
  task automatic to_scan_end();
    do cyc(); while (k % 32 != 31);
  endtask

  // Expected anodes with blinking off: 2 guard cycles then the slot's digit
  function automatic logic [3:0] an_of(int kk);
    int c;
    int i;
    c = kk % 8;
    i = (kk / 8) % 4;
    if (c < 2) return 4'hF;
    return ~(4'b0001 << i);
  endfunction

  task automatic set_d(input logic [3:0] a3, a2, a1, a0);
    D3 = a3; D2 = a2; D1 = a1; D0 = a0;
  endtask

  task automatic test_reset();
    RST = 1'b0; TRG = 1'b0; ACK = 1'b0;
    BLANK_LZ = 1'b0; DP_MASK = 4'h0;
    set_d(4'd1, 4'd2, 4'd3, 4'd4);
    repeat (3) @(negedge CLK);
    n_chk++; if (AN !== 4'hF) begin n_fail++;
      $display("FAIL reset_an: got %h want F", AN); end
    n_chk++; if (SEG !== 7'h7F) begin n_fail++;
      $display("FAIL reset_seg: got %h want 7f", SEG); end
    n_chk++; if (DP !== 1'b1) begin n_fail++;
      $display("FAIL reset_dp: got %b want 1", DP); end
    n_chk++; if (ALARM !== 1'b0) begin n_fail++;
      $display("FAIL reset_alarm: got %b want 0", ALARM); end
  endtask

  task automatic test_scan();
    logic [6:0] tab [4];
    logic [6:0] es;
    tab = '{7'h19, 7'h30, 7'h24, 7'h79};
    release_rst();
    for (int j = 0; j < 64; j++) begin
      cyc();
      n_chk++; if (AN !== an_of(k)) begin n_fail++;
        $display("FAIL scan_an k=%0d: got %h want %h", k, AN, an_of(k)); end
      if (an_of(k) != 4'hF) begin
        es = (k < 32) ? 7'h40 : tab[(k / 8) % 4];
        n_chk++; if (SEG !== es) begin n_fail++;
          $display("FAIL scan_seg k=%0d: got %h want %h", k, SEG, es); end
        n_chk++; if (DP !== 1'b1) begin n_fail++;
          $display("FAIL scan_dp k=%0d: got %b want 1", k, DP); end
      end
    end
  endtask

  task automatic test_blank();
    logic [6:0] t0 [4];
    logic [6:0] t1 [4];
    logic       ed;
    t0 = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    t1 = '{7'h78, 7'h40, 7'h12, 7'h7F};
    BLANK_LZ = 1'b1;
    set_d(4'd0, 4'd0, 4'd0, 4'd0);
    to_scan_end();
    for (int j = 0; j < 32; j++) begin
      cyc();
      if (an_of(k) != 4'hF) begin
        n_chk++; if (SEG !== t0[(k / 8) % 4]) begin n_fail++;
          $display("FAIL blank_zero k=%0d: got %h want %h",
                   k, SEG, t0[(k / 8) % 4]); end
      end
    end
    set_d(4'd0, 4'd5, 4'd0, 4'd7);
    DP_MASK = 4'b1000;
    to_scan_end();
    for (int j = 0; j < 32; j++) begin
      cyc();
      n_chk++; if (AN !== an_of(k)) begin n_fail++;
        $display("FAIL blank_an k=%0d: got %h want %h", k, AN, an_of(k)); end
      if (an_of(k) != 4'hF) begin
        ed = ((k / 8) % 4 == 3) ? 1'b0 : 1'b1;
        n_chk++; if (SEG !== t1[(k / 8) % 4]) begin n_fail++;
          $display("FAIL blank_mix k=%0d: got %h want %h",
                   k, SEG, t1[(k / 8) % 4]); end
        n_chk++; if (DP !== ed) begin n_fail++;
          $display("FAIL blank_dp k=%0d: got %b want %b", k, DP, ed); end
      end
    end
    DP_MASK = 4'h0;
  endtask

  task automatic test_snapshot();
    logic [6:0] t_old [4];
    logic [6:0] t_new [4];
    t_old = '{7'h78, 7'h40, 7'h12, 7'h7F};
    t_new = '{7'h79, 7'h02, 7'h00, 7'h10};
    for (int j = 0; j < 32; j++) begin
      cyc();
      if (j == 9) set_d(4'd9, 4'd8, 4'd6, 4'd1);
      if (an_of(k) != 4'hF) begin
        n_chk++; if (SEG !== t_old[(k / 8) % 4]) begin n_fail++;
          $display("FAIL snap_hold k=%0d: got %h want %h",
                   k, SEG, t_old[(k / 8) % 4]); end
      end
    end
    for (int j = 0; j < 32; j++) begin
      cyc();
      if (an_of(k) != 4'hF) begin
        n_chk++; if (SEG !== t_new[(k / 8) % 4]) begin n_fail++;
          $display("FAIL snap_new k=%0d: got %h want %h",
                   k, SEG, t_new[(k / 8) % 4]); end
      end
    end
  endtask

  task automatic test_alarm();
    logic [3:0] ea;
    BLANK_LZ = 1'b0;
    do cyc(); while (k % 32 != 29);
    TRG = 1'b1;
    cyc();
    TRG = 1'b0;
    n_chk++; if (ALARM !== 1'b0) begin n_fail++;
      $display("FAIL alarm_early: got %b want 0", ALARM); end
    cyc();
    n_chk++; if (ALARM !== 1'b1) begin n_fail++;
      $display("FAIL alarm_set: got %b want 1", ALARM); end
    for (int s = 1; s <= 6; s++) begin
      for (int j = 0; j < 32; j++) begin
        cyc();
        ea = (s == 3 || s == 4) ? 4'hF : an_of(k);
        n_chk++; if (AN !== ea) begin n_fail++;
          $display("FAIL blink_an s=%0d k=%0d: got %h want %h",
                   s, k, AN, ea); end
      end
    end
    cyc();
    n_chk++; if (AN !== 4'hF) begin n_fail++;
      $display("FAIL blink_off2: got %h want F", AN); end
    ACK = 1'b1;
    cyc();
    ACK = 1'b0;
    n_chk++; if (ALARM !== 1'b0) begin n_fail++;
      $display("FAIL alarm_ack: got %b want 0", ALARM); end
    to_scan_end();
    for (int j = 0; j < 96; j++) begin
      cyc();
      n_chk++; if (AN !== an_of(k)) begin n_fail++;
        $display("FAIL steady_an k=%0d: got %h want %h", k, AN, an_of(k)); end
    end
  endtask

  task automatic test_trg_ack();
    TRG = 1'b1;
    cyc();
    ACK = 1'b1;
    cyc();
    n_chk++; if (ALARM !== 1'b1) begin n_fail++;
      $display("FAIL set_wins: got %b want 1", ALARM); end
    cyc();
    ACK = 1'b0;
    n_chk++; if (ALARM !== 1'b0) begin n_fail++;
      $display("FAIL ack_clear: got %b want 0", ALARM); end
    for (int j = 0; j < 100; j++) begin
      cyc();
      n_chk++; if (ALARM !== 1'b0) begin n_fail++;
        $display("FAIL no_retrig j=%0d: got %b want 0", j, ALARM); end
    end
    TRG = 1'b0;
    cyc();
  endtask

  task automatic test_dash_reset();
    set_d(4'd9, 4'd8, 4'd6, 4'hC);
    to_scan_end();
    repeat (5) cyc();
    n_chk++; if (AN !== 4'hE) begin n_fail++;
      $display("FAIL dash_an: got %h want E", AN); end
    n_chk++; if (SEG !== 7'h3F) begin n_fail++;
      $display("FAIL dash_seg: got %h want 3f", SEG); end
    TRG = 1'b1;
    cyc();
    TRG = 1'b0;
    cyc();
    n_chk++; if (ALARM !== 1'b1) begin n_fail++;
      $display("FAIL pre_rst_alarm: got %b want 1", ALARM); end
    #2;
    RST = 1'b0;
    #1;
    n_chk++; if (AN !== 4'hF) begin n_fail++;
      $display("FAIL async_an: got %h want F", AN); end
    n_chk++; if (SEG !== 7'h7F) begin n_fail++;
      $display("FAIL async_seg: got %h want 7f", SEG); end
    n_chk++; if (DP !== 1'b1) begin n_fail++;
      $display("FAIL async_dp: got %b want 1", DP); end
    n_chk++; if (ALARM !== 1'b0) begin n_fail++;
      $display("FAIL async_alarm: got %b want 0", ALARM); end
    release_rst();
    for (int j = 0; j < 12; j++) begin
      cyc();
      n_chk++; if (AN !== an_of(k)) begin n_fail++;
        $display("FAIL rerel_an k=%0d: got %h want %h", k, AN, an_of(k)); end
      if (k == 2) begin
        n_chk++; if (SEG !== 7'h40) begin n_fail++;
          $display("FAIL rerel_seg: got %h want 40", SEG); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blank();
    test_snapshot();
    test_alarm();
    test_trg_ack();
    test_dash_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: CLK cycles each digit is shown; legal range 8..2^20.
REQ-002 SHALL have parameter GUARD, default 16: CLK cycles at the start of each digit slot with all anodes off; legal range 0..SCAN_DIV-1.
REQ-003 SHALL have parameter BLINK_SCANS, default 64: full 4-digit scans per blink half-period.
REQ-004 SHALL have port CLK  in  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port RST  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports D0..D3  in  4 each  BCD digit values; D0 is rightmost (seconds ones), D3 is leftmost (minutes tens).
REQ-007 SHALL have port DP_MASK  in  4  decimal point enable per digit; bit n selects digit n.
REQ-008 SHALL have port BLANK_LZ  in  1  leading-zero blanking enable.
REQ-009 SHALL have port TRG  in  1  terminal-count pulse from the counter chain.
REQ-010 SHALL have port ACK  in  1  alarm acknowledge.
REQ-011 SHALL have port AN  out  4  anode enables, active-low; bit n drives digit n.
REQ-012 SHALL have port SEG  out  7  segments a..g, active-low; SEG[0]=a, SEG[6]=g.
REQ-013 SHALL have port DP  out  1  decimal point, active-low.
REQ-014 SHALL have port ALARM  out  1  latched alarm flag.

Function
REQ-015 Prescaler SHALL count 0..SCAN_DIV-1, wrap to 0, and assert a one-cycle tick on the terminal value.
REQ-016 Digit index SHALL advance 0->1->2->3->0 on each tick.
REQ-017 D0..D3 SHALL be captured into a snapshot only on the tick where the index wraps 3->0, so no scan mixes old and new values.
REQ-018 AN, SEG and DP SHALL be registered, reflecting index, prescaler and snapshot with exactly 1 CLK of latency.
REQ-019 For prescaler values 0..GUARD-1, AN SHALL be 4'hF; otherwise exactly one AN bit SHALL be low.
REQ-020 Decode SHALL use standard 7-segment patterns for 0-9, and values 10-15 SHALL display a dash (only g lit).
REQ-021 With BLANK_LZ=1: digit 3 SHALL blank if 0; digit 2 SHALL blank if it and digit 3 are 0; digit 1 SHALL blank if digits 1-3 are all 0; digit 0 SHALL never blank.
REQ-022 A blanked digit SHALL drive SEG=7'h7F, keep its anode active, and still show DP if its DP_MASK bit is set.
REQ-023 A rising edge of TRG, detected synchronously with a 1-cycle registered delay, SHALL set ALARM; ACK=1 SHALL clear it.
REQ-024 If a TRG rising edge and ACK occur in the same cycle, set SHALL win.
REQ-025 While ALARM=1, blink phase SHALL toggle every BLINK_SCANS full scans, and the off phase SHALL force AN=4'hF.
REQ-026 Clearing ALARM SHALL reset the blink phase to on and the blink counter to 0.
REQ-027 While TRG is held high, ALARM SHALL NOT retrigger; a new rising edge is required.

Reset
REQ-028 While RST=0: AN=4'hF, SEG=7'h7F, DP=1, ALARM=0, and prescaler, index, snapshot, blink counter and TRG history SHALL all be 0.
REQ-029 Reset assertion SHALL take effect immediately, mid-scan or mid-blink.
REQ-030 After release, the first tick SHALL occur SCAN_DIV cycles later.

Structure
REQ-031 A shared package SHALL hold the segment pattern constants (0-9, dash, blank) and the 2-bit digit-index type.
REQ-032 BCD-to-segment decode SHALL be a separate combinational sub-module, seg_decoder.

Verification (SCAN_DIV=8, GUARD=2, BLINK_SCANS=2)
REQ-033 Release reset with D3..D0=1,2,3,4 -> in the first scan all digits show 0 (snapshot reset); from the second scan, AN cycles E,D,B,7 with SEG 0x19,0x30,0x24,0x79, and AN=F for 2 cycles per slot.
REQ-034 BLANK_LZ=1, D3..D0=0,0,0,0 -> digits 3-1 SEG=7F, digit 0 SEG=40; with D3..D0=0,5,0,7, digit 3 is blanked and digit 1 shows 40.
REQ-035 Change D inputs mid-scan (index 1) -> no change until the scan after the 3->0 wrap.
REQ-036 One-cycle TRG pulse -> ALARM=1 two cycles later, AN=F on alternate 2-scan windows; ACK -> ALARM=0 and display steady on.
REQ-037 TRG edge with simultaneous ACK -> ALARM=1; TRG held high for 100 cycles after ACK -> ALARM stays 0.
REQ-038 D0=4'hC -> digit 0 SEG=3F; assert RST mid-slot -> outputs reach reset values in the same cycle.
